// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 16;

    localparam int ERR_OVR = 2;
    localparam int ERR_FRM = 1;
    localparam int ERR_PAR = 0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - restartable down-counter producing mid-bit and full-bit sample strobes
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic mid_tick,
    output logic full_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic             first;
    logic             at_zero;

    // first marks the half-period leading into the start-bit centre
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            first <= 1'b0;
        end else if (restart) begin
            cnt   <= HALF_LOAD;
            first <= 1'b1;
        end else if (run) begin
            if (cnt == '0) begin
                cnt   <= FULL_LOAD;
                first <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else begin
            cnt   <= '0;
            first <= 1'b0;
        end
    end

    assign at_zero   = run && !restart && (cnt == '0);
    assign mid_tick  = at_zero && first;
    assign full_tick = at_zero && !first;

endmodule

// File: rtl/uart_rx_status.sv
// rtl/uart_rx_status.sv - UART receiver with valid/ready byte output and sticky error status
module uart_rx_status
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [2:0] err,
    input  logic       err_clr
);

    logic [1:0] sync_q;
    logic [1:0] warm;
    logic       rxd_s;
    logic       prev_high;
    logic       fall;

    rx_state_t  state;
    rx_state_t  state_next;
    logic       restart;
    logic       mid_tick;
    logic       full_tick;

    logic [2:0] bit_cnt;
    logic [7:0] shift_q;
    logic       par_q;
    logic       done_q;
    logic       done_frm;
    logic       done_par;
    logic       overrun;
    logic [2:0] err_set;

    assign rxd_s = sync_q[1];
    assign fall  = prev_high && !rxd_s;

    // prev_high only trusts the synchronizer once it has refilled after reset,
    // so a line already low at release never looks like a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            warm      <= 2'b00;
            prev_high <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rxd};
            warm      <= {warm[0], 1'b1};
            prev_high <= warm[1] && rxd_s;
        end
    end

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .run      (state != IDLE),
        .mid_tick (mid_tick),
        .full_tick(full_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                    restart    = 1'b1;
                end
            end
            START:      if (mid_tick) state_next = rxd_s ? IDLE : DATA;
            DATA: begin
                if (full_tick && bit_cnt == 3'd7) begin
                    state_next = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY:     if (full_tick) state_next = STOP;
            STOP:       if (full_tick) state_next = rxd_s ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (rxd_s) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            done_q   <= 1'b0;
            done_frm <= 1'b0;
            done_par <= 1'b0;
        end else begin
            if (state == DATA && full_tick) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift_q <= {rxd_s, shift_q[7:1]};
            end
            if (state == PARITY && full_tick) begin
                par_q <= rxd_s;
            end
            done_q   <= (state == STOP) && full_tick;
            done_frm <= !rxd_s;
            done_par <= PARITY_EN && ((^shift_q) ^ par_q);
        end
    end

    assign overrun = done_q && rx_valid && !rx_ready;

    always_comb begin
        err_set          = 3'b000;
        err_set[ERR_OVR] = overrun;
        err_set[ERR_FRM] = done_q && done_frm;
        err_set[ERR_PAR] = done_q && done_par;
    end

    // a byte completing on the same edge as a transfer replaces the old one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            err      <= 3'b000;
        end else begin
            if (done_q && !overrun) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            err <= (err_clr ? 3'b000 : err) | err_set;
        end
    end

endmodule

// File: tb/tb_uart_rx_status.sv
// tb/tb_uart_rx_status.sv - directed and random frames checked against a frame-level reference model
module tb_uart_rx_status;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b0;
    logic       rx_ready = 1'b1;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] err;

    int         total = 0;
    int         bad = 0;
    logic [7:0] got_q[$];
    int         valid_cycles = 0;

    uart_rx_status #(
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxd     (rxd),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    // expected status contribution of one frame: {overrun, frame, parity}
    function automatic logic [2:0] frame_err(input logic [7:0] d, input logic p, input logic s);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        ones += int'(p);
        return {1'b0, !s, (ones % 2) == 1};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    initial begin
        int         base;
        int         vc0;
        logic [7:0] d;
        logic       p;
        logic [2:0] exp_err;
        logic [7:0] exp_q[$];

        tick(3);
        check("reset_data", 32'(rx_data), 32'h00);
        check("reset_valid", 32'(rx_valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_state", 32'(dut.state), 32'(IDLE));

        base = got_q.size();
        rst_n = 1'b1;
        tick(5 * CPB);
        check("low_at_release_valid", 32'(rx_valid), 32'h0);
        check("low_at_release_state", 32'(dut.state), 32'(IDLE));
        rxd = 1'b1;
        tick(2 * CPB);
        check("low_at_release_bytes", 32'(got_q.size()), 32'(base));

        base = got_q.size();
        vc0 = valid_cycles;
        send_frame(8'hA5, 1'b0, 1'b1);
        tick(2 * CPB);
        check("a5_count", 32'(got_q.size()), 32'(base + 1));
        check("a5_data", 32'(got_q[base]), 32'hA5);
        check("a5_pulse", 32'(valid_cycles - vc0), 32'd1);
        check("a5_err", 32'(err), 32'(frame_err(8'hA5, 1'b0, 1'b1)));

        base = got_q.size();
        send_frame(8'h3C, 1'b1, 1'b1);
        tick(2 * CPB);
        check("3c_data", 32'(got_q[base]), 32'h3C);
        check("3c_err", 32'(err), 32'b001);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("3c_err_clr", 32'(err), 32'h0);

        base = got_q.size();
        send_frame(8'h81, 1'b0, 1'b0);
        tick(40 * CPB);
        check("brk_err", 32'(err), 32'b010);
        check("brk_state", 32'(dut.state), 32'(BREAK_WAIT));
        check("brk_data", 32'(got_q[base]), 32'h81);
        rxd = 1'b1;
        tick(3 * CPB);
        check("brk_idle", 32'(dut.state), 32'(IDLE));
        check("brk_count", 32'(got_q.size()), 32'(base + 1));
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;

        rx_ready = 1'b0;
        base = got_q.size();
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        tick(2 * CPB);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_err", 32'(err), 32'b100);
        rx_ready = 1'b1;
        tick(1);
        check("ovr_drain_valid", 32'(rx_valid), 32'h0);
        check("ovr_count", 32'(got_q.size()), 32'(base + 1));
        check("ovr_kept", 32'(got_q[base]), 32'h11);

        vc0 = valid_cycles;
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        tick(2 * CPB);
        check("glitch_valid", 32'(valid_cycles - vc0), 32'd0);
        check("glitch_err", 32'(err), 32'b100);
        check("glitch_state", 32'(dut.state), 32'(IDLE));

        base = got_q.size();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
        rxd = 1'b0;
        tick(CPB / 2);
        rst_n = 1'b0;
        rxd = 1'b1;
        tick(3);
        check("midrst_err", 32'(err), 32'h0);
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        tick(2 * CPB);
        send_frame(8'h5A, 1'b0, 1'b1);
        tick(2 * CPB);
        check("midrst_count", 32'(got_q.size()), 32'(base + 1));
        check("midrst_data", 32'(got_q[base]), 32'h5A);
        check("midrst_err_after", 32'(err), 32'h0);

        exp_err = 3'b000;
        base = got_q.size();
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            p = ^d;
            if ($urandom_range(0, 3) == 0) p = !p;
            send_frame(d, p, 1'b1);
            exp_q.push_back(d);
            exp_err |= frame_err(d, p, 1'b1);
            tick(CPB * $urandom_range(0, 2));
        end
        tick(2 * CPB);
        check("rnd_count", 32'(got_q.size()), 32'(base + exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rnd_data_%0d", i), 32'(got_q[base + i]), 32'(exp_q[i]));
        end
        check("rnd_err", 32'(err), 32'(exp_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_status.md
UART_RX_STATUS -- requirements
Module: uart_rx_status

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit period; legal values 4..65535.
REQ-002 Parameter PARITY_EN, default 1, 1 = 8E1 frame with even parity bit, 0 = 8N1 frame.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port rxd  input  1  asynchronous serial line; idles high.
REQ-006 Port rx_data  output  8  received byte, LSB first on the line.
REQ-007 Port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 Port rx_ready  input  1  consumer accepts rx_data.
REQ-009 Port err  output  3  sticky status {overrun, frame, parity}; drives one 3-input OR channel of the downstream error-combine stage.
REQ-010 Port err_clr  input  1  clears all err bits.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE -> START on a synchronized falling edge.
- START: sample at CLKS_PER_BIT/2. Low -> DATA. High -> IDLE (glitch rejected, no flags set).
- DATA: 8 samples, each CLKS_PER_BIT after the previous one. Then PARITY if PARITY_EN, else STOP.
- PARITY: one sample.
- STOP: one sample. High -> IDLE. Low -> BREAK_WAIT.
- BREAK_WAIT -> IDLE once the line is sampled high.
REQ-013 Bit counter SHALL be 3 bits and wrap 7->0 on leaving DATA; the baud counter SHALL be wide enough for CLKS_PER_BIT-1.
REQ-014 On the stop-bit sample, the byte SHALL be loaded into rx_data and rx_valid set on the next clk edge (latency = 1 clk after the stop sample).
REQ-015 The byte SHALL be delivered even when a parity or frame error occurred.
REQ-016 Handshake:
- A transfer occurs on a clk edge with rx_valid && rx_ready.
- rx_valid drops after the transfer unless a new byte loads on the same edge, in which case rx_valid stays 1 and rx_data updates.
- rx_data SHALL be stable while rx_valid=1 and no transfer has occurred.
REQ-017 Overrun: a new byte completes while rx_valid=1 and rx_ready=0.
- err[2] SHALL set.
- The new byte SHALL be dropped.
- The old rx_data SHALL be kept.
REQ-018 err[1] SHALL set when the stop sample is low.
REQ-019 err[0] SHALL set when PARITY_EN=1 and XOR(data bits, parity bit)=1.
REQ-020 err bits SHALL be sticky until err_clr=1.
- err_clr clears all three bits on the next edge.
- If err_clr and a new error event fall on the same edge, the new error SHALL win (bit ends at 1).
REQ-021 err SHALL not change on a rejected start glitch.

Reset
REQ-022 While rst_n=0, outputs SHALL be: rx_data=8'h00, rx_valid=0, err=3'b000.
REQ-023 While rst_n=0, the FSM SHALL be in IDLE, counters at 0, and synchronizer flops at 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no byte and no flag.
REQ-025 After reset release, the receiver SHALL wait for a fresh falling edge; a line already low SHALL not start a frame.

Structure
REQ-026 A shared package uart_pkg SHALL hold:
- the FSM state enum;
- the err bit index constants ERR_OVR=2, ERR_FRM=1, ERR_PAR=0;
- the default CLKS_PER_BIT.
REQ-027 One sub-module, uart_baud_tick, SHALL generate the mid-bit and full-bit sample strobes from a restartable down-counter.
REQ-028 All other logic SHALL be flat in uart_rx_status.

Verification (CLKS_PER_BIT=16, PARITY_EN=1)
REQ-029 Send 0xA5, parity 0, stop 1, rx_ready=1 -> rx_data=8'hA5, rx_valid pulses for 1 clk, err=3'b000.
REQ-030 Send 0x3C with parity 1 -> rx_data=8'h3C, err=3'b001; assert err_clr -> err=3'b000 on the next edge.
REQ-031 Send 0x81 with stop bit 0, line held low for 40 bit times -> err=3'b010, FSM in BREAK_WAIT until line high, no second byte delivered.
REQ-032 rx_ready=0; send 0x11 then 0x22 -> rx_data stays 8'h11, err=3'b100; then rx_ready=1 -> rx_valid=0 after one edge.
REQ-033 Drive a 5-clk low pulse on rxd -> no rx_valid, err unchanged, FSM back in IDLE.
REQ-034 Assert rst_n=0 during bit 4 of a frame, release, send 0x5A -> only 8'h5A delivered, err=3'b000.
